// File: rtl/cpu_pkg.sv
// Shared datapath definitions: shift/rotate op encodings and word geometry.
package cpu_pkg;

  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned SHAMT_BITS = 5;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t SH_SHR  = 3'b000;
  localparam shift_op_t SH_SHRA = 3'b001;
  localparam shift_op_t SH_SHL  = 3'b010;
  localparam shift_op_t SH_ROR  = 3'b011;
  localparam shift_op_t SH_ROL  = 3'b100;

  function automatic logic op_is_legal(input shift_op_t op);
    return op <= SH_ROL;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter/rotator; carry output exists only with SHIFT_ROTATE_CARRY_EN.
module shift_core
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_WIDTH,
  parameter int unsigned AMT_BITS = SHAMT_BITS
) (
  input  shift_op_t           op,
  input  logic [WIDTH-1:0]    operand,
  input  logic [AMT_BITS-1:0] n,
  output logic [WIDTH-1:0]    result,
  output logic                illegal
`ifdef SHIFT_ROTATE_CARRY_EN
  ,
  output logic                carry
`endif
);

  logic [AMT_BITS-1:0] neg_n;
  logic [AMT_BITS-1:0] rot_r;
  logic [AMT_BITS-1:0] rot_l;

  // ROL is a right rotate by (WIDTH - n) mod WIDTH; n = 0 yields shifts by 0 on both sides.
  always_comb begin
    neg_n   = -n;
    rot_r   = (op == SH_ROL) ? neg_n : n;
    rot_l   = -rot_r;
    illegal = !op_is_legal(op);
    case (op)
      SH_SHR:         result = operand >> n;
      SH_SHRA:        result = $signed(operand) >>> n;
      SH_SHL:         result = operand << n;
      SH_ROR, SH_ROL: result = (operand >> rot_r) | (operand << rot_l);
      default:        result = operand;
    endcase
  end

`ifdef SHIFT_ROTATE_CARRY_EN
  always_comb begin
    carry = 1'b0;
    if (n != '0) begin
      case (op)
        SH_SHR, SH_SHRA: carry = operand[n - AMT_BITS'(1)];
        SH_SHL:          carry = operand[neg_n];
        SH_ROR:          carry = result[WIDTH-1];
        SH_ROL:          carry = result[0];
        default:         carry = 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: rtl/shift_rotate_stage.sv
// Two-stage pipelined shift/rotate unit with valid/ready on both sides.
// Optional carry output enabled by defining SHIFT_ROTATE_CARRY_EN.
module shift_rotate_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH    = WORD_WIDTH,
  parameter int unsigned AMT_BITS = SHAMT_BITS
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             illegal
`ifdef SHIFT_ROTATE_CARRY_EN
  ,
  output logic             carry
`endif
);

  logic                s1_valid;
  shift_op_t           s1_op;
  logic [WIDTH-1:0]    s1_operand;
  logic [AMT_BITS-1:0] s1_n;
  logic                s2_valid;

  logic                s2_free;
  logic                accept;
  logic                move;
  logic [WIDTH-1:0]    core_result;
  logic                core_illegal;
  logic                unused_amount_hi;
`ifdef SHIFT_ROTATE_CARRY_EN
  logic                core_carry;
`endif

  assign unused_amount_hi = ^amount[WIDTH-1:AMT_BITS];

  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign move      = s1_valid && s2_free;
  assign out_valid = s2_valid;

  shift_core #(
    .WIDTH   (WIDTH),
    .AMT_BITS(AMT_BITS)
  ) u_core (
    .op     (s1_op),
    .operand(s1_operand),
    .n      (s1_n),
    .result (core_result),
    .illegal(core_illegal)
`ifdef SHIFT_ROTATE_CARRY_EN
    ,
    .carry  (core_carry)
`endif
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_operand <= '0;
      s1_n       <= '0;
      s2_valid   <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      illegal    <= 1'b0;
`ifdef SHIFT_ROTATE_CARRY_EN
      carry      <= 1'b0;
`endif
    end else begin
      // A new accept refills S1 in the same edge that its old contents move to S2.
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_op      <= op;
        s1_operand <= operand;
        s1_n       <= amount[AMT_BITS-1:0];
      end else if (move) begin
        s1_valid <= 1'b0;
      end

      if (move) begin
        s2_valid <= 1'b1;
        result   <= core_result;
        zero     <= (core_result == '0);
        negative <= core_result[WIDTH-1];
        illegal  <= core_illegal;
`ifdef SHIFT_ROTATE_CARRY_EN
        carry    <= core_carry;
`endif
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_rotate_stage.sv
// Self-checking bench for shift_rotate_stage: directed cases, backpressure, clear, random stream.
module tb_shift_rotate_stage;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] operand;
  logic [31:0] amount;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        illegal;
`ifdef SHIFT_ROTATE_CARRY_EN
  logic        carry;
`endif

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic        last_acc = 1'b0;

  always #5 clock = ~clock;

  shift_rotate_stage #(
    .WIDTH   (32),
    .AMT_BITS(5)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand  (operand),
    .amount   (amount),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .negative (negative),
    .illegal  (illegal)
`ifdef SHIFT_ROTATE_CARRY_EN
    ,
    .carry    (carry)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic obs_carry();
`ifdef SHIFT_ROTATE_CARRY_EN
    return carry;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [35:0] observed();
    return {obs_carry(), illegal, negative, zero, result};
  endfunction

  // Reference: {carry, illegal, negative, zero, result}
  function automatic logic [35:0] model(input logic [2:0] mop, input logic [31:0] x,
                                        input logic [31:0] amt);
    int          n;
    logic [63:0] d;
    logic [63:0] t;
    logic [31:0] r;
    logic        c;
    logic        ill;
    n   = int'(amt % 32);
    d   = {x, x};
    r   = x;
    c   = 1'b0;
    ill = (mop > 3'd4);
    if (!ill && n != 0) begin
      case (mop)
        3'd0: begin r = x >> n; c = x[n-1]; end
        3'd1: begin r = x[31] ? ~((~x) >> n) : (x >> n); c = x[n-1]; end
        3'd2: begin r = x << n; c = x[32-n]; end
        3'd3: begin t = d >> n; r = t[31:0]; c = r[31]; end
        default: begin t = d << n; r = t[63:32]; c = r[0]; end
      endcase
    end
`ifndef SHIFT_ROTATE_CARRY_EN
    c = 1'b0;
`endif
    return {c, ill, r[31], (r == 32'd0), r};
  endfunction

  // Stream scoreboard: every accept is predicted, every drain is compared in order.
  always @(negedge clock) begin
    last_acc = 1'b0;
    if (clear) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("q_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) check("stream", 64'(observed()), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, operand, amount));
        last_acc = 1'b1;
      end
    end
  end

  task automatic run_one(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] a, input logic [31:0] er, input logic ez,
                         input logic en, input logic ei, input logic ec);
    int lat;
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = o;
    operand   = x;
    amount    = a;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (in_ready) break;
    end
    check({tag, "_accept"}, 64'(in_ready), 64'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      lat++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'(2));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_flags"}, 64'({zero, negative, illegal}), 64'({ez, en, ei}));
`ifdef SHIFT_ROTATE_CARRY_EN
    check({tag, "_carry"}, 64'(carry), 64'(ec));
`else
    if (ec === 1'bx) $display("note: unreachable");
`endif
  endtask

  logic [2:0]  bp_op  [3] = '{3'd3, 3'd3, 3'd3};
  logic [31:0] bp_x   [3] = '{32'h000000F1, 32'h00000002, 32'h00000003};
  logic [31:0] bp_a   [3] = '{32'd4, 32'd1, 32'd1};
  logic [31:0] bp_exp [3] = '{32'h1000000F, 32'h00000001, 32'h80000001};

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int idx;
    int nout;
    int first;
    int last;
    logic acc_now;

    clear     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    operand   = '0;
    amount    = '0;
    repeat (3) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_outputs", 64'(observed()), 64'(0));

    run_one("ror1",     3'd3, 32'h80000001, 32'd1,  32'hC0000000, 0, 1, 0, 1);
    run_one("rol4",     3'd4, 32'h80000001, 32'd4,  32'h00000018, 0, 0, 0, 0);
    run_one("shl31",    3'd2, 32'h00000001, 32'd31, 32'h80000000, 0, 1, 0, 0);
    run_one("shr31",    3'd0, 32'h80000000, 32'd31, 32'h00000001, 0, 0, 0, 0);
    run_one("shra31",   3'd1, 32'h80000000, 32'd31, 32'hFFFFFFFF, 0, 1, 0, 0);
    run_one("shra30",   3'd1, 32'h40000000, 32'd30, 32'h00000001, 0, 0, 0, 0);
    run_one("ror_n32",  3'd3, 32'h12345678, 32'd32, 32'h12345678, 0, 0, 0, 0);
    run_one("illegal",  3'd6, 32'hDEADBEEF, 32'd5,  32'hDEADBEEF, 0, 1, 1, 0);
    run_one("shr_zero", 3'd0, 32'h00000001, 32'd1,  32'h00000000, 1, 0, 0, 1);

    // Backpressure: three back-to-back RORs with the consumer stalled.
    @(posedge clock); #1;
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    in_valid = 1'b1;
    op = bp_op[0]; operand = bp_x[0]; amount = bp_a[0];
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      acc_now = in_ready;
      if (cyc == 2) begin
        check("bp_stall_ready", 64'(in_ready), 64'(0));
        check("bp_hold_result", 64'(result), 64'(bp_exp[0]));
      end
      @(posedge clock); #1;
      if (acc_now) begin
        acc++;
        idx++;
        if (idx < 3) begin
          op = bp_op[idx]; operand = bp_x[idx]; amount = bp_a[idx];
        end
      end
    end
    check("bp_accepts", 64'(acc), 64'(2));
    out_ready = 1'b1;
    nout = 0;
    first = 0;
    last = 0;
    for (int cyc = 0; cyc < 10 && nout < 3; cyc++) begin
      @(negedge clock);
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        check("bp_order", 64'(result), 64'(bp_exp[nout]));
        if (nout == 0) first = cyc;
        last = cyc;
        nout++;
      end
      @(posedge clock); #1;
      if (acc_now) in_valid = 1'b0;
    end
    check("bp_count", 64'(nout), 64'(3));
    check("bp_rate", 64'(last - first), 64'(2));

    // Clear with both stages occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op = 3'd3; operand = 32'hFFFFFFFF; amount = 32'd3;
    acc = 0;
    for (int cyc = 0; cyc < 10 && acc < 2; cyc++) begin
      @(negedge clock);
      acc_now = in_ready;
      @(posedge clock); #1;
      if (acc_now) acc++;
    end
    in_valid = 1'b0;
    check("clr_filled_valid", 64'(out_valid), 64'(1));
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    @(negedge clock);
    check("clr_out_valid", 64'(out_valid), 64'(0));
    check("clr_in_ready", 64'(in_ready), 64'(1));
    check("clr_outputs", 64'(observed()), 64'(0));
    run_one("post_clear", 3'd2, 32'h0000000F, 32'd4, 32'h000000F0, 0, 0, 0, 0);

    // Random stream with random stalls on both sides.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clock); #1;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(3) != 0);
        op       = 3'($urandom_range(7));
        operand  = $urandom;
        case ($urandom_range(3))
          0: amount = $urandom;
          1: amount = $urandom & 32'hFFFFFFE0;
          2: amount = 32'd32;
          default: amount = ($urandom_range(1) != 0) ? 32'd31 : 32'd1;
        endcase
      end
      out_ready = ($urandom_range(3) != 0);
    end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(out_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rotate_stage.md
Name: shift_rotate_stage

Overview:
- Two-stage pipelined shift/rotate execution unit for the datapath ALU.
- Consumes operands gated from the bus (operand A, shift amount in B).
- Produces a registered 32-bit result plus flags for the Z-register load path.
- Supports SHR, SHRA, SHL, ROR and ROL.
- Uses a valid/ready handshake on both sides, so the control unit can stall it.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two.
- AMT_BITS, 5, number of shift-amount bits used, equal to log2(WIDTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-high reset.
- in_valid  in  1  the operand set on op/operand/amount is valid.
- in_ready  out  1  the stage can accept an operand set this cycle.
- op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101–111 illegal.
- operand  in  WIDTH  value to be shifted or rotated.
- amount  in  WIDTH  shift count; only amount[AMT_BITS-1:0] is used and the upper bits are ignored.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  the consumer (Z load) accepts the result this cycle.
- result  out  WIDTH  shifted or rotated value.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- illegal  out  1  op was 101–111; in that case result = operand unchanged.

Behaviour:
- Clock and reset: single clock named clock; reset named clear, synchronous and active-high.
- Reset values: every output register is 0, including out_valid, result, zero, negative, illegal and carry. Both stage valid bits are 0.
- in_ready = !s1_valid || s2_free, where s2_free = !s2_valid || out_ready.
- Stage 1 (S1): on in_valid && in_ready, capture op, operand and amount[AMT_BITS-1:0] and set s1_valid.
- Stage 2 (S2): when s1_valid && s2_free, compute the result combinationally from the S1 registers, register result and flags, and set s2_valid.
  - S1 clears in the same cycle unless a new input is accepted in that cycle.
- out_valid = s2_valid. S2 clears on out_ready when no new S1 data moves in that cycle.
- Latency: 2 cycles from the accepting edge to out_valid with no stall. Throughput: 1 per cycle.
- Stall: while out_valid && !out_ready, result and flags hold stable. in_ready drops only once S1 is also full. No item is lost or reordered.
- Arithmetic, with n = amount[AMT_BITS-1:0]:
  - SHR: logical shift right, zero fill.
  - SHRA: shift right with sign fill.
  - SHL: shift left, zero fill.
  - ROR: rotate right by n.
  - ROL: computed as ROR by (WIDTH - n) mod WIDTH.
  - n = 0 returns operand unchanged for every op.
  - amount = 32 aliases to n = 0.
- Flags are computed from the registered S2 result.
- Simultaneous events: S2 drain, S1→S2 move and a new accept can all happen in one edge.
- clear has priority over all of these.
- clear mid-operation discards both stages immediately; outputs read reset values on the next cycle.

Optional Feature:
- Macro: SHIFT_ROTATE_CARRY_EN.
- When defined: extra output carry (1 bit), registered in S2 with result.
  - SHR/SHRA: carry = operand[n-1].
  - SHL: carry = operand[WIDTH-n].
  - ROR: carry = result[WIDTH-1].
  - ROL: carry = result[0].
  - n = 0 or illegal op: carry = 0.
- When undefined: no carry port and no carry logic; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the op encoding constants SH_SHR, SH_SHRA, SH_SHL, SH_ROR, SH_ROL;
  - the typedef shift_op_t (3 bits);
  - the constants WORD_WIDTH = 32 and SHAMT_BITS = 5.
- One natural sub-module, shift_core: a purely combinational WIDTH-bit barrel shifter/rotator (op, operand, n → result, carry), instantiated between S1 and S2.
- Handshake and pipeline registers stay in the top module.

Test Plan:
- ROR 0x80000001 by 1, out_ready=1 → result 0xC0000000, negative=1, zero=0, out_valid exactly 2 cycles after accept; with the macro, carry=1.
- ROL 0x80000001 by 4 → 0x00000018. SHL 0x00000001 by 31 → 0x80000000. SHR 0x80000000 by 31 → 0x00000001.
- SHRA 0x80000000 by 31 → 0xFFFFFFFF, negative=1. SHRA 0x40000000 by 30 → 0x00000001.
- amount=0x00000020 (n=0) with ROR on 0x12345678 → 0x12345678. op=110 → result = operand, illegal=1. SHR 0x00000001 by 1 → 0, zero=1.
- Backpressure: issue 3 back-to-back ROR items with out_ready=0 → in_ready drops after 2 accepts. Raise out_ready → 3 results in issue order, 1 per cycle, none lost.
- Assert clear while both stages are full → next cycle out_valid=0, result=0, in_ready=1. A subsequent single op completes normally.
